// File: rtl/seq_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter_pkg
// Purpose  : Shared definitions for the iterative shifter: shift opcodes,
//            controller state encoding and the effective step-count function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_shifter_pkg;

  // Shift opcodes, shared with the combinational shifter.
  localparam logic [4:0] OP_LSL = 5'd8;
  localparam logic [4:0] OP_LSR = 5'd10;
  localparam logic [4:0] OP_ASR = 5'd14;
  localparam logic [4:0] OP_ROR = 5'd22;

  // Controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_known_op(input logic [4:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) || (op == OP_ROR);
  endfunction

  // Number of single-bit steps needed. Linear shifts saturate at width+1:
  // every count beyond that yields the same result and carry. Rotates wrap
  // modulo the width. Unknown ops take no steps.
  function automatic int unsigned eff_count(input logic [4:0] op,
                                            input int unsigned amount,
                                            input int unsigned width);
    int unsigned n;
    n = 0;
    if ((op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR)) begin
      n = (amount > width + 1) ? width + 1 : amount;
    end else if (op == OP_ROR) begin
      n = amount % width;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shifter_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-bit shift/rotate step.
// Ports    : op         - shift opcode
//            r          - current value
//            carry      - current carry
//            r_next     - value after one step
//            carry_next - carry after one step
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] r,
  input  logic             carry,
  output logic [WIDTH-1:0] r_next,
  output logic             carry_next
);

  always_comb begin
    r_next     = r;
    carry_next = carry;
    case (op)
      OP_LSL: begin
        carry_next = r[WIDTH-1];
        r_next     = {r[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        carry_next = r[0];
        r_next     = {1'b0, r[WIDTH-1:1]};
      end
      OP_ASR: begin
        carry_next = r[0];
        r_next     = {r[WIDTH-1], r[WIDTH-1:1]};
      end
      OP_ROR: begin
        carry_next = r[0];
        r_next     = {r[0], r[WIDTH-1:1]};
      end
      default: begin
        r_next     = r;
        carry_next = carry;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter
// Purpose  : Iterative shift/rotate unit, one bit per clock, valid/ready
//            handshake on both sides, ARM-style carry/zero/negative flags.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            in_valid/in_ready   - request handshake (ready only in IDLE)
//            a, amount, shift_op - operand, shift count, opcode
//            carry_in            - current C flag
//            out_valid/out_ready - result handshake (held until accepted)
//            result, carry_out, zero, neg, op_err - result and flags
//            busy                - controller not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amount,
  input  logic [4:0]       shift_op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             neg,
  output logic             op_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             op_err_q, op_err_d;

  logic [WIDTH-1:0] step_r;
  logic             step_c;
  logic [CNT_W-1:0] n_eff;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op         (op_q),
    .r          (r_q),
    .carry      (carry_q),
    .r_next     (step_r),
    .carry_next (step_c)
  );

  assign n_eff = CNT_W'(eff_count(shift_op, 32'(amount), WIDTH));

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    op_err_d = op_err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d     = shift_op;
          r_d      = a;
          cnt_d    = n_eff;
          op_err_d = ~is_known_op(shift_op);
          // A nonzero rotate by a multiple of the width leaves the value
          // unchanged but reports the msb as carry. Otherwise carry_in is
          // the zero-step answer, and a shift overwrites it anyway.
          if ((shift_op == OP_ROR) && (amount != '0)) begin
            carry_d = a[WIDTH-1];
          end else begin
            carry_d = carry_in;
          end
          if (n_eff == '0) begin
            state_d = ST_DONE;
            zero_d  = ~|a;
            neg_d   = a[WIDTH-1];
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        r_d     = step_r;
        carry_d = step_c;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          zero_d  = ~|step_r;
          neg_d   = step_r[WIDTH-1];
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      op_err_q <= op_err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = r_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign op_err    = op_err_q;

endmodule
`default_nettype wire

// File: doc/seq_shifter.md
# seq_shifter

Iterative, parametrised shift/rotate unit for the reduced-ARM datapath. It is the multi-cycle successor of the combinational shifter and uses the same shift opcodes. It shifts one bit per clock under a valid/ready handshake and produces ARM-style carry-out, zero and negative flags. It sits between the register-file A bus and the ALU writeback mux, so that wide datapaths can share one shifter without a full barrel array.

## Interface
Parameters:
- WIDTH, 16, operand/result width (≥ 4)
- AMT_W, 5, shift-amount width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- a  in  WIDTH  operand (A bus)
- amount  in  AMT_W  shift amount (imm5 / register)
- shift_op  in  5  LSL=8, LSR=10, ASR=14, ROR=22
- carry_in  in  1  current C flag
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  shifted value
- carry_out  out  1  last bit shifted out
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- op_err  out  1  shift_op not one of the four codes
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, latch a, op and carry_in, then compute the effective count n:
  - LSL/LSR/ASR: n = min(amount, WIDTH+1). Results are identical to the uncapped count.
  - ROR: n = amount mod WIDTH. If amount≠0 and n==0, result=a and carry=a[WIDTH-1].
  - Unknown op: n=0, result=a, carry=carry_in, op_err=1.
  - n==0 → DONE; otherwise → SHIFT.
- SHIFT: one step per cycle.
  - LSL: carry←r[W-1], r←{r[W-2:0],0}.
  - LSR: carry←r[0], r←{0,r[W-1:1]}.
  - ASR: carry←r[0], r←{r[W-1],r[W-1:1]}.
  - ROR: carry←r[0], r←{r[0],r[W-1:1]}.
  - Decrement count; after the step that makes it 0 → DONE.
- amount==0 on any valid op: result=a, carry_out=carry_in.
- DONE: out_valid=1. result and all flags are stable. On out_ready → IDLE. in_valid is ignored outside IDLE.
- zero, neg and op_err are registered together with result.
- Reset (any state, including mid-SHIFT): state=IDLE. in_ready=1 on the first cycle after reset is released. All other outputs are 0. The pending request is discarded.

## Timing
- The accept edge is edge 0. out_valid is asserted after edge n, so the latency is n cycles; n=0 gives out_valid in the cycle after accept.
- Worst case is WIDTH+1 cycles (LSL/LSR/ASR with amount>WIDTH).
- Back-to-back issue: in_ready returns the cycle after the out_valid&&out_ready edge. The minimum period is n+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Count register width: $clog2(WIDTH+2).

## Structure
- seq_shifter_pkg holds:
  - opcode localparams OP_LSL/OP_LSR/OP_ASR/OP_ROR
  - the state encoding
  - a function returning the effective count
- One sub-module, shift_step: combinational single-bit step with inputs op, r and carry, producing r_next and carry_next. It is reused by the combinational shifter rewrite.

## Test plan
WIDTH=16, a=16'hF084.
- LSL, amount 4 → result 0840, carry 1, zero 0; out_valid after edge 4.
- LSR, amount 3 → result 1E10, carry 1; ASR, amount 20 → result FFFF, carry 1, neg 1, out_valid after edge 17.
- ROR, amount 20 → result 4F08, carry 0, 4 cycles. ROR, amount 16 → result F084, carry 1, out_valid after edge 0.
- LSL, amount 0, carry_in=1 → result F084, carry 1. Op 5'b00011 → op_err 1, result F084.
- out_ready held low 3 cycles in DONE → result held, in_ready low. A second in_valid during this time is ignored and accepted only after release.
- rst_n low for 1 cycle mid-SHIFT → next cycle IDLE, out_valid 0, result 0. The next request completes correctly.
